// File: rtl/splitter_pkg.sv
// rtl/splitter_pkg.sv - shared types and helpers for the round-robin splitter
`timescale 1ns/1ps
package splitter_pkg;

    typedef enum logic {
        SPLIT_STRICT = 1'b0,
        SPLIT_SKIP   = 1'b1
    } split_mode_e;

    // Cyclic increment with an explicit wrap so non-power-of-two port counts work.
    function automatic int unsigned next_port(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/splitter_rr_if.sv
// rtl/splitter_rr_if.sv - master stream, slave fan-out and selection FIFO signals
`timescale 1ns/1ps
interface splitter_rr_if #(
    parameter int PORTS_N   = 4,
    parameter int DATA_W    = 32,
    parameter int SEL_DEPTH = 4
);
    localparam int PORTS_W = ($clog2(PORTS_N) > 1) ? $clog2(PORTS_N) : 1;
    localparam int CNT_W   = $clog2(SEL_DEPTH + 1);

    logic                i_master_valid;
    logic                o_master_ready;
    logic [DATA_W-1:0]   i_master_data;
    logic [PORTS_N-1:0]  o_slave_valid;
    logic [PORTS_N-1:0]  i_slave_ready;
    logic [DATA_W-1:0]   o_slave_data;
    logic                o_sel_valid;
    logic                i_sel_ready;
    logic [PORTS_W-1:0]  o_sel_idx;
    logic [CNT_W-1:0]    o_sel_count;

    modport slave (
        input  i_master_valid, i_master_data, i_slave_ready, i_sel_ready,
        output o_master_ready, o_slave_valid, o_slave_data,
               o_sel_valid, o_sel_idx, o_sel_count
    );

    modport master (
        output i_master_valid, i_master_data, i_slave_ready, i_sel_ready,
        input  o_master_ready, o_slave_valid, o_slave_data,
               o_sel_valid, o_sel_idx, o_sel_count
    );

endinterface

// File: rtl/splitter_sel_fifo.sv
// rtl/splitter_sel_fifo.sv - synchronous FIFO holding destination indices of accepted beats
`timescale 1ns/1ps
module splitter_sel_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         valid_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    // Head reads as zero when empty so stale storage never leaks out.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_reset_n) !(push_i && full_o));
    a_count_bound:  assert property (@(posedge i_clk) disable iff (!i_reset_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/splitter_rr.sv
// rtl/splitter_rr.sv - round-robin fan-out of one stream to PORTS_N workers with order-tracking FIFO
`timescale 1ns/1ps
module splitter_rr
    import splitter_pkg::*;
#(
    parameter int          PORTS_N   = 4,
    parameter int          DATA_W    = 32,
    parameter int          SEL_DEPTH = 4,
    parameter split_mode_e MODE      = SPLIT_STRICT
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    splitter_rr_if.slave    bus
);
    localparam int PORTS_W = ($clog2(PORTS_N) > 1) ? $clog2(PORTS_N) : 1;

    logic [PORTS_W-1:0] r_ptr_q, r_ptr_d;
    logic [PORTS_W-1:0] cand_idx [PORTS_N];
    logic [PORTS_N-1:0] cand_rdy;
    logic [PORTS_W-1:0] skip_target, target;
    logic               any_rdy, tgt_rdy, valid_en, full, master_ready, fire;

    // Candidate k is port (r_ptr + k) mod PORTS_N; bit k of cand_rdy is its ready.
    for (genvar k = 0; k < PORTS_N; k++) begin : g_scan
        logic [PORTS_W:0] raw;
        assign raw         = {1'b0, r_ptr_q} + (PORTS_W+1)'(k);
        assign cand_idx[k] = (raw >= (PORTS_W+1)'(PORTS_N)) ?
                             PORTS_W'(raw - (PORTS_W+1)'(PORTS_N)) : raw[PORTS_W-1:0];
        assign cand_rdy[k] = bus.i_slave_ready[cand_idx[k]];
    end

    always_comb begin
        skip_target = r_ptr_q;
        for (int k = PORTS_N - 1; k >= 0; k--) begin
            if (cand_rdy[k]) skip_target = cand_idx[k];
        end
    end

    assign any_rdy = |bus.i_slave_ready;
    assign target  = (MODE == SPLIT_SKIP) ? skip_target : r_ptr_q;
    assign tgt_rdy = (MODE == SPLIT_SKIP) ? any_rdy : bus.i_slave_ready[r_ptr_q];
    // Strict valid ignores slave ready; skip valid only exists once some slave is ready.
    assign valid_en = bus.i_master_valid & ~full & ((MODE == SPLIT_SKIP) ? any_rdy : 1'b1);

    assign master_ready       = tgt_rdy & ~full;
    assign fire               = bus.i_master_valid & master_ready;
    assign bus.o_master_ready = master_ready;
    assign bus.o_slave_valid  = valid_en ? (PORTS_N'(1) << target) : '0;
    assign bus.o_slave_data   = DATA_W'(bus.i_master_data);

    assign r_ptr_d = fire ? PORTS_W'(next_port(32'(target), PORTS_N)) : r_ptr_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= r_ptr_d;
        end
    end

    splitter_sel_fifo #(
        .WIDTH (PORTS_W),
        .DEPTH (SEL_DEPTH)
    ) u_sel_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .push_i      (fire),
        .push_data_i (target),
        .pop_i       (bus.i_sel_ready),
        .head_o      (bus.o_sel_idx),
        .valid_o     (bus.o_sel_valid),
        .full_o      (full),
        .count_o     (bus.o_sel_count)
    );

    a_onehot_valid: assert property (@(posedge i_clk) disable iff (!i_reset_n) $onehot0(bus.o_slave_valid));

endmodule
